// File: rtl/mem_stage_if.sv
// Data-memory / bridge port driven by the MEM stage.
// The master side issues address, byte enables and store data; the slave returns the read word.
interface mem_stage_if;
    logic [31:0] m_data_rdata;
    logic [31:0] m_data_addr;
    logic [31:0] m_data_wdata;
    logic [3:0]  m_data_byteen;
    logic [31:0] m_inst_addr;

    modport master (
        input  m_data_rdata,
        output m_data_addr,
        output m_data_wdata,
        output m_data_byteen,
        output m_inst_addr
    );

    modport slave (
        output m_data_rdata,
        input  m_data_addr,
        input  m_data_wdata,
        input  m_data_byteen,
        input  m_inst_addr
    );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage: lane-aligned stores, sign-extended loads and the MEM/WB register.
// Killed instructions (reset, CP0 flush or upstream exception) write nothing and become WB bubbles.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] MEM_pc,
    input  logic [31:0] MEM_instr,
    input  logic [31:0] MEM_out,
    input  logic [31:0] MEM_rt,
    input  logic [4:0]  MEM_exc,
    mem_stage_if.master dm,
    output logic [4:0]  MEM_exc_CP0,
    output logic [31:0] MEM_res_WB,
    output logic [31:0] MEM_instr_WB,
    output logic [31:0] MEM_pc_WB
);

    localparam logic [5:0] OP_LW = 6'b100011;
    localparam logic [5:0] OP_LH = 6'b100001;
    localparam logic [5:0] OP_LB = 6'b100000;
    localparam logic [5:0] OP_SW = 6'b101011;
    localparam logic [5:0] OP_SH = 6'b101001;
    localparam logic [5:0] OP_SB = 6'b101000;

    logic [5:0]  opcode;
    logic [1:0]  a;
    logic        kill;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [15:0] ld_half;
    logic [7:0]  ld_byte;
    logic [31:0] res_sel;

    logic [31:0] res_wb_d,   res_wb_q;
    logic [31:0] instr_wb_d, instr_wb_q;
    logic [31:0] pc_wb_d,    pc_wb_q;

    assign opcode = MEM_instr[31:26];
    assign a      = MEM_out[1:0];
    assign kill   = rst | req | (MEM_exc != 5'd0);

    // Store lanes; wdata is held at zero whenever nothing is written.
    always_comb begin
        byteen = '0;
        wdata  = '0;
        if (!kill) begin
            case (opcode)
                OP_SW: begin
                    byteen = 4'b1111;
                    wdata  = MEM_rt;
                end
                OP_SH: begin
                    byteen = a[1] ? 4'b1100 : 4'b0011;
                    wdata  = {2{MEM_rt[15:0]}};
                end
                OP_SB: begin
                    byteen = 4'b0001 << a;
                    wdata  = {4{MEM_rt[7:0]}};
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        ld_half = a[1] ? dm.m_data_rdata[31:16] : dm.m_data_rdata[15:0];
        case (a)
            2'd0:    ld_byte = dm.m_data_rdata[7:0];
            2'd1:    ld_byte = dm.m_data_rdata[15:8];
            2'd2:    ld_byte = dm.m_data_rdata[23:16];
            default: ld_byte = dm.m_data_rdata[31:24];
        endcase
    end

    always_comb begin
        case (opcode)
            OP_LW:   res_sel = dm.m_data_rdata;
            OP_LH:   res_sel = {{16{ld_half[15]}}, ld_half};
            OP_LB:   res_sel = {{24{ld_byte[7]}}, ld_byte};
            default: res_sel = MEM_out;
        endcase
    end

    always_comb begin
        res_wb_d   = '0;
        instr_wb_d = '0;
        pc_wb_d    = '0;
        if (!kill) begin
            res_wb_d   = res_sel;
            instr_wb_d = MEM_instr;
            pc_wb_d    = MEM_pc;
        end
    end

    always_ff @(posedge clk) begin
        res_wb_q   <= res_wb_d;
        instr_wb_q <= instr_wb_d;
        pc_wb_q    <= pc_wb_d;
    end

    assign dm.m_data_addr   = MEM_out;
    assign dm.m_data_wdata  = wdata;
    assign dm.m_data_byteen = byteen;
    assign dm.m_inst_addr   = MEM_pc;
    assign MEM_exc_CP0      = MEM_exc;
    assign MEM_res_WB       = res_wb_q;
    assign MEM_instr_WB     = instr_wb_q;
    assign MEM_pc_WB        = pc_wb_q;

endmodule

// File: tb/tb_mem_stage.sv
// Randomised self-checking bench for mem_stage against a byte-level reference model.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] MEM_pc, MEM_instr, MEM_out, MEM_rt;
    logic [4:0]  MEM_exc;
    logic [4:0]  MEM_exc_CP0;
    logic [31:0] MEM_res_WB, MEM_instr_WB, MEM_pc_WB;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mem_stage_if bus ();

    mem_stage dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .MEM_pc       (MEM_pc),
        .MEM_instr    (MEM_instr),
        .MEM_out      (MEM_out),
        .MEM_rt       (MEM_rt),
        .MEM_exc      (MEM_exc),
        .dm           (bus.master),
        .MEM_exc_CP0  (MEM_exc_CP0),
        .MEM_res_WB   (MEM_res_WB),
        .MEM_instr_WB (MEM_instr_WB),
        .MEM_pc_WB    (MEM_pc_WB)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LB = 6'b100000;
    localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
    localparam logic [5:0] ORI = 6'b001101, SPECIAL = 6'b000000, LUI = 6'b001111;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    function automatic int unsigned access_bytes(input logic [5:0] op);
        case (op)
            LW, SW:  return 4;
            LH, SH:  return 2;
            LB, SB:  return 1;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] mk_instr(input logic [5:0] op);
        return {op, 26'($urandom)};
    endfunction

    // One cycle: apply inputs after the falling edge, check combinational outputs,
    // then check the WB register just after the rising edge.
    task automatic step(input logic r, input logic q, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [31:0] out, input logic [31:0] rt, input logic [4:0] exc,
                        input logic [31:0] rdata);
        logic [5:0]  op;
        int unsigned n, base;
        bit          is_load, is_store, killed;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_res;
        longint      v;

        rst = r; req = q; MEM_pc = pc; MEM_instr = instr; MEM_out = out; MEM_rt = rt;
        MEM_exc = exc; bus.m_data_rdata = rdata;

        op       = instr[31:26];
        n        = access_bytes(op);
        is_load  = (op == LW) || (op == LH) || (op == LB);
        is_store = (op == SW) || (op == SH) || (op == SB);
        killed   = r || q || (exc != 5'd0);
        base     = (n == 0) ? 0 : (int'(out[1:0]) & ~(n - 1));

        exp_be = '0;
        exp_wd = '0;
        if (is_store && !killed) begin
            for (int i = 0; i < 4; i++) begin
                if (i >= int'(base) && i < int'(base + n)) exp_be[i] = 1'b1;
                exp_wd[8*i +: 8] = rt[8*(i % n) +: 8];
            end
        end

        exp_res = out;
        if (is_load) begin
            v = longint'((64'(rdata) >> (8*base)) & ((64'd1 << (8*n)) - 64'd1));
            if (((v >> (8*n - 1)) & 64'd1) != 0) v = v - longint'(64'd1 << (8*n));
            exp_res = v[31:0];
        end

        #1;
        check("byteen",   32'(bus.m_data_byteen), 32'(exp_be));
        check("wdata",    bus.m_data_wdata, exp_wd);
        check("addr",     bus.m_data_addr, out);
        check("inst_addr", bus.m_inst_addr, pc);
        check("exc_cp0",  32'(MEM_exc_CP0), 32'(exc));

        @(posedge clk);
        #1;
        check("res_wb",   MEM_res_WB,   killed ? 32'd0 : exp_res);
        check("instr_wb", MEM_instr_WB, killed ? 32'd0 : instr);
        check("pc_wb",    MEM_pc_WB,    killed ? 32'd0 : pc);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0]  ops [9];
        logic [5:0]  op;
        logic [4:0]  exc;
        logic [31:0] sw_w;

        ops = '{LW, LH, LB, SW, SH, SB, ORI, SPECIAL, LUI};
        rst = 1'b1; req = 1'b0; MEM_pc = '0; MEM_instr = '0; MEM_out = '0; MEM_rt = '0;
        MEM_exc = '0; bus.m_data_rdata = '0;
        @(negedge clk);

        // Reset state with a store present: nothing written, WB all zero.
        step(1'b1, 1'b0, 32'h0040_0000, mk_instr(SW), 32'h0000_0100, 32'h1111_2222, 5'd0, 32'h0);

        sw_w = mk_instr(SW);
        step(1'b0, 1'b0, 32'h0040_0004, sw_w, 32'h0000_0100, 32'h1234_5678, 5'd0, 32'h0);
        check("sw_instr_wb", MEM_instr_WB, sw_w);
        step(1'b0, 1'b0, 32'h0040_0008, mk_instr(SB), 32'h0000_0103, 32'h0000_00AB, 5'd0, 32'h0);
        step(1'b0, 1'b0, 32'h0040_000C, mk_instr(SH), 32'h0000_0102, 32'h0000_BEEF, 5'd0, 32'h0);

        step(1'b0, 1'b0, 32'h0040_0010, mk_instr(LH), 32'h0000_0102, 32'h0, 5'd0, 32'h8001_1234);
        check("lh_res", MEM_res_WB, 32'hFFFF_8001);
        step(1'b0, 1'b0, 32'h0040_0014, mk_instr(LB), 32'h0000_0101, 32'h0, 5'd0, 32'h0000_7F00);
        check("lb_res", MEM_res_WB, 32'h0000_007F);
        step(1'b0, 1'b0, 32'h0040_0018, mk_instr(LW), 32'h0000_0100, 32'h0, 5'd0, 32'h8001_1234);
        check("lw_res", MEM_res_WB, 32'h8001_1234);

        // Misaligned store flagged upstream: suppressed and bubbled.
        step(1'b0, 1'b0, 32'h0040_001C, mk_instr(SW), 32'h0000_0102, 32'hCAFE_F00D, 5'd5, 32'h0);
        check("ades_instr_wb", MEM_instr_WB, 32'h0);

        step(1'b0, 1'b0, 32'h0040_0020, mk_instr(ORI), 32'h0000_FFFF, 32'h0, 5'd0, 32'h0);
        check("ori_res", MEM_res_WB, 32'h0000_FFFF);
        step(1'b0, 1'b1, 32'h0040_0024, mk_instr(SW), 32'h0000_0100, 32'h5555_AAAA, 5'd0, 32'h0);

        step(1'b1, 1'b0, 32'h0040_0028, mk_instr(LW), 32'h0000_0100, 32'h0, 5'd0, 32'h1234_5678);
        step(1'b0, 1'b0, 32'h0040_002C, mk_instr(LW), 32'h0000_0200, 32'h0, 5'd0, 32'hDEAD_BEEF);
        check("lw_after_rst", MEM_res_WB, 32'hDEAD_BEEF);

        for (int k = 0; k < 300; k++) begin
            op  = ops[$urandom_range(0, 8)];
            exc = 5'd0;
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 2))
                    0:       exc = 5'd4;
                    1:       exc = 5'd5;
                    default: exc = 5'd12;
                endcase
            end
            step($urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0, $urandom, mk_instr(op),
                 $urandom, $urandom, exc, $urandom);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
